// File: rtl/ps2_tx_funcmod_if.sv
// rtl/ps2_tx_funcmod_if.sv - command handshake between control logic and the PS/2 transmitter
interface ps2_tx_funcmod_if;
  logic       iCall;
  logic [7:0] iData;
  logic       oDone;
  logic       oErr;
  logic       oBusy;

  modport master (
    output iCall,
    output iData,
    input  oDone,
    input  oErr,
    input  oBusy
  );

  modport slave (
    input  iCall,
    input  iData,
    output oDone,
    output oErr,
    output oBusy
  );
endinterface

// File: rtl/ps2_tx_funcmod.sv
// rtl/ps2_tx_funcmod.sv - PS/2 host-to-device command transmitter (request-to-send, 11-fall frame, ack check)
module ps2_tx_funcmod #(
  parameter int unsigned T_INHIBIT = 5000,
  parameter int unsigned T_TIMEOUT = 1000000
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  inout  wire                     PS2_CLK,
  inout  wire                     PS2_DAT,
  ps2_tx_funcmod_if.slave         bus
);

  localparam int unsigned T_MAX = (T_INHIBIT > T_TIMEOUT) ? T_INHIBIT : T_TIMEOUT;
  localparam int          CW    = $clog2(T_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(T_INHIBIT - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(T_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_WAITIDLE,
    S_DONE,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [8:0]    sr_q, sr_d;
  logic [3:0]    n_q, n_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
  logic          clk_low_q, clk_low_d;
  logic          dat_low_q, dat_low_d;

  logic clk_s, dat_s, fall, tmo_hit;

  // Open-drain pads: only ever pull low, otherwise float for the external pull-up.
  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign clk_s   = clk_sync_q[1];
  assign dat_s   = dat_sync_q[1];
  assign fall    = clk_prev_q & ~clk_s;
  assign tmo_hit = (tmr_q == TMO_LAST);

  assign bus.oDone = (state_q == S_DONE);
  assign bus.oErr  = err_q;
  assign bus.oBusy = (state_q != S_IDLE);

  // Synchronisers reset to 1 (idle bus level) so reset release cannot fake a fall.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_s;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      n_q       <= '0;
      tmr_q     <= '0;
      err_q     <= 1'b0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      n_q       <= n_d;
      tmr_q     <= tmr_d;
      err_q     <= err_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    n_d       = n_q;
    tmr_d     = tmr_q;
    err_d     = err_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;

    case (state_q)
      S_IDLE: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        if (bus.iCall) begin
          // Frame payload kept as {odd parity, data}, shifted out LSB first.
          sr_d      = {~^bus.iData, bus.iData};
          err_d     = 1'b0;
          tmr_d     = '0;
          n_d       = '0;
          clk_low_d = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (tmr_q == INH_LAST) begin
          tmr_d     = '0;
          dat_low_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_RTS: begin
        clk_low_d = 1'b0;
        n_d       = '0;
        tmr_d     = '0;
        state_d   = S_XFER;
      end

      S_XFER: begin
        if (tmo_hit) begin
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (fall) begin
            n_d = n_q + 4'd1;
            if (n_q <= 4'd8) begin
              dat_low_d = ~sr_q[0];
              sr_d      = {1'b0, sr_q[8:1]};
            end else if (n_q == 4'd9) begin
              dat_low_d = 1'b0;
            end else begin
              err_d   = dat_s;
              state_d = S_WAITIDLE;
            end
          end
        end
      end

      S_WAITIDLE: begin
        if (tmo_hit) begin
          clk_low_d = 1'b0;
          dat_low_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (clk_s && dat_s) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (!bus.iCall) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_tx_funcmod.sv
// tb/tb_ps2_tx_funcmod.sv - randomized bench with a keyboard-side device model and frame reference
module tb_ps2_tx_funcmod;

  localparam int T_INH = 40;
  localparam int T_TMO = 3000;

  logic clk;
  logic rst_n;
  logic dev_clk_low;
  logic dev_dat_low;
  wire  ps2_clk;
  wire  ps2_dat;

  int          n_checks;
  int          n_errors;
  int unsigned cyc;
  int          done_cnt;

  ps2_tx_funcmod_if bus ();

  ps2_tx_funcmod #(
    .T_INHIBIT (T_INH),
    .T_TIMEOUT (T_TMO)
  ) dut (
    .CLOCK   (clk),
    .RESET   (rst_n),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .bus     (bus)
  );

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.oDone === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host request is recognised once clock floats high while data is still held low.
  task automatic wait_req(output bit req, output int clk_low_n, output bit dat_seen);
    req = 0; clk_low_n = 0; dat_seen = 0;
    for (int k = 0; k < T_INH + 100; k++) begin
      @(negedge clk);
      if (ps2_clk === 1'b0) begin
        clk_low_n++;
        if (ps2_dat === 1'b0) dat_seen = 1;
      end else if (ps2_dat === 1'b0) begin
        req = 1;
        break;
      end
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, input int half, input bit ack,
                         input bit drop_early, input int hold, input int abort_fall);
    logic [9:0] frame, exp_frame;
    bit req, dat_seen, got_done, clk_bad, busy_bad;
    int clk_low_n, d0;
    logic err;
    exp_frame = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
    frame = '0; err = 1'b0; got_done = 0; clk_bad = 0; busy_bad = 0;
    d0 = done_cnt;
    @(negedge clk);
    bus.iData = d;
    bus.iCall = 1'b1;
    wait_req(req, clk_low_n, dat_seen);
    check("request_seen", 32'(req), 32'd1);
    if (!req) begin
      bus.iCall = 1'b0;
      return;
    end
    check("inhibit_long_enough", 32'(clk_low_n >= T_INH), 32'd1);
    check("start_bit_under_inhibit", 32'(dat_seen), 32'd1);
    bus.iData = ~d;
    if (drop_early) bus.iCall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b1;
      if (abort_fall == i + 1) begin
        repeat (half / 2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_dat_released", 32'(ps2_dat), 32'd1);
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_done", 32'(bus.oDone), 32'd0);
        dev_clk_low = 1'b0;
        #1;
        check("rst_clk_released", 32'(ps2_clk), 32'd1);
        bus.iCall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        return;
      end
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b0;
      frame[i] = ps2_dat;
    end
    if (ack) dev_dat_low = 1'b1;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    check("frame", 32'(frame), 32'(exp_frame));
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.oDone === 1'b1) begin
        got_done = 1;
        err = bus.oErr;
        break;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("err_at_done", 32'(err), 32'(!ack));
    if (!drop_early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (ps2_clk !== 1'b1) clk_bad = 1;
        if (bus.oBusy !== 1'b1) busy_bad = 1;
      end
      check("hold_no_inhibit", 32'(clk_bad), 32'd0);
      check("hold_busy", 32'(busy_bad), 32'd0);
      bus.iCall = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("busy_after", 32'(bus.oBusy), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("lines_idle", 32'({ps2_clk, ps2_dat}), 32'b11);
    check("err_holds", 32'(bus.oErr), 32'(!ack));
  endtask

  task automatic do_timeout(input logic [7:0] d);
    bit req, dat_seen, got_done;
    int clk_low_n;
    int unsigned t0, t1;
    logic err;
    got_done = 0; err = 1'b0; t1 = 0;
    @(negedge clk);
    bus.iData = d;
    bus.iCall = 1'b1;
    wait_req(req, clk_low_n, dat_seen);
    check("tmo_request_seen", 32'(req), 32'd1);
    t0 = cyc;
    for (int k = 0; k < T_TMO + 100; k++) begin
      @(negedge clk);
      if (bus.oDone === 1'b1) begin
        got_done = 1;
        t1 = cyc;
        err = bus.oErr;
        break;
      end
    end
    check("tmo_done_seen", 32'(got_done), 32'd1);
    check("tmo_latency", t1 - t0, 32'(T_TMO));
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_lines_released", 32'({ps2_clk, ps2_dat}), 32'b11);
    bus.iCall = 1'b0;
    repeat (3) @(negedge clk);
    check("tmo_busy_after", 32'(bus.oBusy), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; done_cnt = 0;
    rst_n = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    bus.iCall = 1'b0;
    bus.iData = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.oBusy), 32'd0);
    check("reset_done", 32'(bus.oDone), 32'd0);
    check("reset_err", 32'(bus.oErr), 32'd0);
    check("reset_lines", 32'({ps2_clk, ps2_dat}), 32'b11);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_xfer(8'hED, 20, 1'b1, 1'b0, 5, 0);
    do_xfer(8'h00, 15, 1'b1, 1'b0, 2, 0);
    do_xfer(8'h01, 15, 1'b1, 1'b0, 2, 0);
    do_xfer(8'h55, 12, 1'b0, 1'b0, 2, 0);
    do_xfer(8'h3C, 12, 1'b1, 1'b0, 1000, 0);
    for (int r = 0; r < 6; r++) begin
      do_xfer(8'($urandom), $urandom_range(10, 30), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 20), 0);
    end
    do_timeout(8'hA7);
    do_xfer(8'hA5, 20, 1'b1, 1'b0, 2, 5);
    do_xfer(8'hFF, 20, 1'b1, 1'b0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
